// File: rtl/sr_fde_pipe_pkg.sv
// Shared opcodes, funct fields, ALU codes and stage-register layouts for the fetch/decode/execute front end.
package sr_fde_pipe_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_B   = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BGE     = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_SRL  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_SUB  = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic    wd_src;
        logic    reg_write;
        logic    branch;
        logic    cond_zero;
        logic    bge;
        logic    alu_src;
        alu_op_t alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [4:0]  rd;
        logic [31:0] imm_i;
        logic [31:0] imm_u;
        logic [31:0] pc_branch;
        logic [31:0] pc_plus4;
    } de_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic        alu_zero;
        logic        alu_neg;
        logic        wd_src;
        logic        reg_write;
        logic        branch;
        logic        cond_zero;
        logic        bge;
        logic [4:0]  rd;
        logic [31:0] imm_u;
        logic [31:0] pc_branch;
        logic [31:0] pc_plus4;
    } ew_t;

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/sr_fde_pipe_if.sv
// Bundle between the pipe front end and its neighbours (imem, hazard/forwarding unit, regfile, writeback).
interface sr_fde_pipe_if;
    logic [31:0] pc_i;
    logic [31:0] imAddr;
    logic [31:0] imData;
    logic        freeze;
    logic [31:0] pcPlus4_f;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic        branch_d;
    logic [31:0] srcA_i;
    logic [31:0] srcB_i;
    logic        wdSrc_o;
    logic        regWrite_o;
    logic        branch_o;
    logic        condZero_o;
    logic        bge_o;
    logic        aluZero_o;
    logic        aluNeg_o;
    logic [31:0] aluResult_o;
    logic [4:0]  rd_o;
    logic [31:0] immU_o;
    logic [31:0] pcBranch_o;
    logic [31:0] pcPlus4_o;

    modport master (
        output pc_i, imData, freeze, srcA_i, srcB_i,
        input  imAddr, pcPlus4_f, rs1_o, rs2_o, branch_d,
        input  wdSrc_o, regWrite_o, branch_o, condZero_o, bge_o,
        input  aluZero_o, aluNeg_o, aluResult_o, rd_o, immU_o, pcBranch_o, pcPlus4_o
    );

    modport slave (
        input  pc_i, imData, freeze, srcA_i, srcB_i,
        output imAddr, pcPlus4_f, rs1_o, rs2_o, branch_d,
        output wdSrc_o, regWrite_o, branch_o, condZero_o, bge_o,
        output aluZero_o, aluNeg_o, aluResult_o, rd_o, immU_o, pcBranch_o, pcPlus4_o
    );
endinterface

// File: rtl/sr_fde_pipe_alu.sv
// Combinational ALU: ADD/OR/SRL/SLTU/SUB with zero and sign flags; zero latency, no flow control.
module sr_fde_pipe_alu
    import sr_fde_pipe_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_op_t     i_op,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_neg
);

    always_comb begin
        o_result = i_a + i_b;
        case (i_op)
            ALU_OR:   o_result = i_a | i_b;
            ALU_SRL:  o_result = i_a >> i_b[4:0];
            ALU_SLTU: o_result = {31'b0, (i_a < i_b)};
            ALU_SUB:  o_result = i_a - i_b;
            default:  o_result = i_a + i_b;
        endcase
    end

    assign o_zero = (o_result == 32'd0);
    assign o_neg  = o_result[31];

endmodule

// File: rtl/sr_fde_pipe.sv
// Fetch/decode/execute front end; imData captured on edge N appears on the E/W outputs after edge N+2.
// No backpressure: freeze only turns the D/E slot into a bubble, fetch keeps following pc_i.
module sr_fde_pipe
    import sr_fde_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
)(
    input logic         clk,
    input logic         rst,
    sr_fde_pipe_if.slave bus
);

    logic [31:0] r_fd_instr;
    logic [31:0] r_fd_pc;
    logic [31:0] r_fd_pc_plus4;
    de_t         r_de;
    ew_t         r_ew;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    ctrl_t       w_ctrl;
    de_t         w_de_next;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic        w_alu_zero;
    logic        w_alu_neg;

    assign bus.imAddr    = bus.pc_i;
    assign bus.pcPlus4_f = bus.pc_i + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fd_instr    <= 32'h0;
            r_fd_pc       <= RESET_PC;
            r_fd_pc_plus4 <= RESET_PC + 32'd4;
        end else begin
            r_fd_instr    <= bus.imData;
            r_fd_pc       <= bus.pc_i;
            r_fd_pc_plus4 <= bus.pc_i + 32'd4;
        end
    end

    assign w_opcode = r_fd_instr[6:0];
    assign w_f3     = r_fd_instr[14:12];
    assign w_f7     = r_fd_instr[31:25];

    // Unlisted encodings fall through with every control low, i.e. a NOP.
    always_comb begin
        w_ctrl = '0;
        case (w_opcode)
            OP_R: begin
                w_ctrl.reg_write = 1'b1;
                case ({w_f7, w_f3})
                    {F7_BASE, F3_ADD_SUB}: w_ctrl.alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD_SUB}: w_ctrl.alu_op = ALU_SUB;
                    {F7_BASE, F3_OR}:      w_ctrl.alu_op = ALU_OR;
                    {F7_BASE, F3_SRL}:     w_ctrl.alu_op = ALU_SRL;
                    {F7_BASE, F3_SLTU}:    w_ctrl.alu_op = ALU_SLTU;
                    default:               w_ctrl.reg_write = 1'b0;
                endcase
            end
            OP_I: begin
                if (w_f3 == F3_ADD_SUB) begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_src   = 1'b1;
                end
            end
            OP_LUI: begin
                w_ctrl.wd_src    = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_B: begin
                case (w_f3)
                    F3_BEQ: begin
                        w_ctrl.branch    = 1'b1;
                        w_ctrl.cond_zero = 1'b1;
                        w_ctrl.alu_op    = ALU_SUB;
                    end
                    F3_BNE: begin
                        w_ctrl.branch = 1'b1;
                        w_ctrl.alu_op = ALU_SUB;
                    end
                    F3_BGE: begin
                        w_ctrl.branch = 1'b1;
                        w_ctrl.bge    = 1'b1;
                        w_ctrl.alu_op = ALU_SUB;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_de_next           = '0;
        w_de_next.ctrl      = w_ctrl;
        w_de_next.rd        = r_fd_instr[11:7];
        w_de_next.imm_i     = {{20{r_fd_instr[31]}}, r_fd_instr[31:20]};
        w_de_next.imm_u     = {r_fd_instr[31:12], 12'b0};
        w_de_next.pc_branch = r_fd_pc + imm_b(r_fd_instr);
        w_de_next.pc_plus4  = r_fd_pc_plus4;
    end

    assign bus.rs1_o    = r_fd_instr[19:15];
    assign bus.rs2_o    = r_fd_instr[24:20];
    assign bus.branch_d = w_ctrl.branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de <= '0;
        end else if (bus.freeze) begin
            r_de <= '0;
        end else begin
            r_de <= w_de_next;
        end
    end

    assign w_alu_b = r_de.ctrl.alu_src ? r_de.imm_i : bus.srcB_i;

    sr_fde_pipe_alu u_alu (
        .i_a      (bus.srcA_i),
        .i_b      (w_alu_b),
        .i_op     (r_de.ctrl.alu_op),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_neg    (w_alu_neg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ew <= '0;
        end else begin
            r_ew.alu_result <= w_alu_result;
            r_ew.alu_zero   <= w_alu_zero;
            r_ew.alu_neg    <= w_alu_neg;
            r_ew.wd_src     <= r_de.ctrl.wd_src;
            r_ew.reg_write  <= r_de.ctrl.reg_write;
            r_ew.branch     <= r_de.ctrl.branch;
            r_ew.cond_zero  <= r_de.ctrl.cond_zero;
            r_ew.bge        <= r_de.ctrl.bge;
            r_ew.rd         <= r_de.rd;
            r_ew.imm_u      <= r_de.imm_u;
            r_ew.pc_branch  <= r_de.pc_branch;
            r_ew.pc_plus4   <= r_de.pc_plus4;
        end
    end

    assign bus.aluResult_o = r_ew.alu_result;
    assign bus.aluZero_o   = r_ew.alu_zero;
    assign bus.aluNeg_o    = r_ew.alu_neg;
    assign bus.wdSrc_o     = r_ew.wd_src;
    assign bus.regWrite_o  = r_ew.reg_write;
    assign bus.branch_o    = r_ew.branch;
    assign bus.condZero_o  = r_ew.cond_zero;
    assign bus.bge_o       = r_ew.bge;
    assign bus.rd_o        = r_ew.rd;
    assign bus.immU_o      = r_ew.imm_u;
    assign bus.pcBranch_o  = r_ew.pc_branch;
    assign bus.pcPlus4_o   = r_ew.pc_plus4;

endmodule

// File: tb/tb_sr_fde_pipe.sv
// Bench for sr_fde_pipe: directed literal cases, then random instruction streams against a mnemonic-level model.
module tb_sr_fde_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sr_fde_pipe_if bus();

    sr_fde_pipe #(.RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef enum int {K_NOP, K_ADD, K_SUB, K_OR, K_SRL, K_SLTU, K_ADDI, K_LUI, K_BEQ, K_BNE, K_BGE} kind_t;

    typedef struct {
        kind_t       kind;
        logic [4:0]  rd;
        logic [31:0] immi;
        logic [31:0] immu;
        logic [31:0] pcb;
        logic [31:0] pc4;
    } slot_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        neg;
        logic        wdsrc;
        logic        regw;
        logic        br;
        logic        cz;
        logic        bge;
        logic [4:0]  rd;
        logic [31:0] immu;
        logic [31:0] pcb;
        logic [31:0] pc4;
    } exp_t;

    logic [31:0] m_fd_instr;
    logic [31:0] m_fd_pc;
    slot_t       m_de;
    exp_t        m_ew;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic kind_t classify(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        if (op == 7'b0110011 && f7 == 7'b0000000) begin
            if (f3 == 3'b000) return K_ADD;
            if (f3 == 3'b110) return K_OR;
            if (f3 == 3'b101) return K_SRL;
            if (f3 == 3'b011) return K_SLTU;
            return K_NOP;
        end
        if (op == 7'b0110011 && f7 == 7'b0100000 && f3 == 3'b000) return K_SUB;
        if (op == 7'b0010011 && f3 == 3'b000) return K_ADDI;
        if (op == 7'b0110111) return K_LUI;
        if (op == 7'b1100011) begin
            if (f3 == 3'b000) return K_BEQ;
            if (f3 == 3'b001) return K_BNE;
            if (f3 == 3'b101) return K_BGE;
        end
        return K_NOP;
    endfunction

    function automatic slot_t decode(input logic [31:0] i, input logic [31:0] pc);
        slot_t s;
        int    off;
        s.kind = classify(i);
        s.rd   = i[11:7];
        s.immi = 32'($signed(i[31:20]));
        s.immu = {i[31:12], 12'h000};
        off    = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
        s.pcb  = pc + 32'(off);
        s.pc4  = pc + 32'd4;
        return s;
    endfunction

    function automatic slot_t bubble();
        slot_t s;
        s.kind = K_NOP;
        s.rd   = '0;
        s.immi = '0;
        s.immu = '0;
        s.pcb  = '0;
        s.pc4  = '0;
        return s;
    endfunction

    function automatic exp_t execute(input slot_t s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        case (s.kind)
            K_ADDI:                 e.res = a + s.immi;
            K_SUB, K_BEQ, K_BNE, K_BGE: e.res = a - b;
            K_OR:                   e.res = a | b;
            K_SRL:                  e.res = a >> (b % 32);
            K_SLTU:                 e.res = (a < b) ? 32'd1 : 32'd0;
            default:                e.res = a + b;
        endcase
        e.zero  = (e.res == 0);
        e.neg   = e.res[31];
        e.wdsrc = (s.kind == K_LUI);
        e.regw  = s.kind inside {K_ADD, K_SUB, K_OR, K_SRL, K_SLTU, K_ADDI, K_LUI};
        e.br    = s.kind inside {K_BEQ, K_BNE, K_BGE};
        e.cz    = (s.kind == K_BEQ);
        e.bge   = (s.kind == K_BGE);
        e.rd    = s.rd;
        e.immu  = s.immu;
        e.pcb   = s.pcb;
        e.pc4   = s.pc4;
        return e;
    endfunction

    task automatic model_reset();
        m_fd_instr = 32'h0;
        m_fd_pc    = 32'h0;
        m_de       = bubble();
        m_ew       = execute(bubble(), 32'h0, 32'h0);
        m_ew.res   = 32'h0;
        m_ew.zero  = 1'b0;
    endtask

    task automatic check_ew();
        chk("aluResult_o", bus.aluResult_o, m_ew.res);
        chk("aluZero_o",   bus.aluZero_o,   m_ew.zero);
        chk("aluNeg_o",    bus.aluNeg_o,    m_ew.neg);
        chk("wdSrc_o",     bus.wdSrc_o,     m_ew.wdsrc);
        chk("regWrite_o",  bus.regWrite_o,  m_ew.regw);
        chk("branch_o",    bus.branch_o,    m_ew.br);
        chk("condZero_o",  bus.condZero_o,  m_ew.cz);
        chk("bge_o",       bus.bge_o,       m_ew.bge);
        chk("rd_o",        bus.rd_o,        m_ew.rd);
        chk("immU_o",      bus.immU_o,      m_ew.immu);
        chk("pcBranch_o",  bus.pcBranch_o,  m_ew.pcb);
        chk("pcPlus4_o",   bus.pcPlus4_o,   m_ew.pc4);
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic frz,
                        input logic [31:0] a, input logic [31:0] b);
        exp_t  nxt_ew;
        slot_t nxt_de;
        bus.imData = ins;
        bus.pc_i   = pc;
        bus.freeze = frz;
        bus.srcA_i = a;
        bus.srcB_i = b;
        #1;
        chk("imAddr",    bus.imAddr,    pc);
        chk("pcPlus4_f", bus.pcPlus4_f, pc + 32'd4);
        chk("rs1_o",     bus.rs1_o,     m_fd_instr[19:15]);
        chk("rs2_o",     bus.rs2_o,     m_fd_instr[24:20]);
        chk("branch_d",  bus.branch_d,  classify(m_fd_instr) inside {K_BEQ, K_BNE, K_BGE});
        nxt_ew = execute(m_de, a, b);
        nxt_de = frz ? bubble() : decode(m_fd_instr, m_fd_pc);
        @(posedge clk);
        #1;
        m_ew       = nxt_ew;
        m_de       = nxt_de;
        m_fd_instr = ins;
        m_fd_pc    = pc;
        check_ew();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_ew();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Instruction under test is fetched, optionally frozen in decode, then executed with operands a/b.
    task automatic run_one(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b, input logic frz);
        step(ins,   pc,          1'b0, 32'h0, 32'h0);
        step(32'h0, pc + 32'd4,  frz,  32'h0, 32'h0);
        step(32'h0, pc + 32'd8,  1'b0, a,     b);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  begin r[31:25] = 7'h00; r[14:12] = 3'b000; r[6:0] = 7'b0110011; end
            1:  begin r[31:25] = 7'h20; r[14:12] = 3'b000; r[6:0] = 7'b0110011; end
            2:  begin r[31:25] = 7'h00; r[14:12] = 3'b110; r[6:0] = 7'b0110011; end
            3:  begin r[31:25] = 7'h00; r[14:12] = 3'b101; r[6:0] = 7'b0110011; end
            4:  begin r[31:25] = 7'h00; r[14:12] = 3'b011; r[6:0] = 7'b0110011; end
            5:  begin r[14:12] = 3'b000; r[6:0] = 7'b0010011; end
            6:  begin r[6:0] = 7'b0110111; end
            7:  begin r[14:12] = 3'b000; r[6:0] = 7'b1100011; end
            8:  begin r[14:12] = 3'b001; r[6:0] = 7'b1100011; end
            9:  begin r[14:12] = 3'b101; r[6:0] = 7'b1100011; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] gen_data();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 15));
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.imData = 32'h0;
        bus.pc_i   = 32'h0;
        bus.freeze = 1'b0;
        bus.srcA_i = 32'h0;
        bus.srcB_i = 32'h0;
        #2;
        do_reset();

        // NOP stream straight after reset
        run_one(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst_regWrite", bus.regWrite_o,  1'b0);
        chk("rst_branch",   bus.branch_o,    1'b0);
        chk("rst_aluRes",   bus.aluResult_o, 32'h0);

        run_one(32'h0050_0093, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("addi_res", bus.aluResult_o, 32'd5);
        chk("addi_rd",  bus.rd_o,        5'd1);
        chk("addi_rw",  bus.regWrite_o,  1'b1);

        run_one(32'h4020_8133, 32'h20, 32'd7, 32'd7, 1'b0);
        chk("sub_zero", bus.aluZero_o,   1'b1);
        chk("sub_res",  bus.aluResult_o, 32'h0);

        run_one(32'h0020_D1B3, 32'h40, 32'h8000_0000, 32'd4, 1'b0);
        chk("srl_res", bus.aluResult_o, 32'h0800_0000);

        run_one(32'h1234_52B7, 32'h60, 32'h0, 32'h0, 1'b0);
        chk("lui_wdsrc", bus.wdSrc_o,   1'b1);
        chk("lui_immu",  bus.immU_o,    32'h1234_5000);
        chk("lui_rd",    bus.rd_o,      5'd5);

        run_one(32'h0020_B1B3, 32'h80, 32'd1, 32'd2, 1'b0);
        chk("sltu_lt", bus.aluResult_o, 32'd1);
        run_one(32'h0020_B1B3, 32'h84, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("sltu_ge", bus.aluResult_o, 32'd0);

        run_one(32'h0020_8463, 32'h10, 32'd9, 32'd9, 1'b0);
        chk("beq_branch", bus.branch_o,   1'b1);
        chk("beq_cz",     bus.condZero_o, 1'b1);
        chk("beq_target", bus.pcBranch_o, 32'h18);
        chk("beq_pc4",    bus.pcPlus4_o,  32'h14);
        chk("beq_rw",     bus.regWrite_o, 1'b0);

        run_one(32'h0020_D463, 32'h30, 32'd3, 32'd5, 1'b0);
        chk("bge_neg", bus.aluNeg_o, 1'b1);
        chk("bge_flag", bus.bge_o,   1'b1);

        run_one(32'h0050_0093, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("frz_rw", bus.regWrite_o, 1'b0);
        chk("frz_br", bus.branch_o,   1'b0);

        // Random streams, freezes and occasional mid-run resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(gen_instr(), $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 9) == 0),
                     gen_data(), gen_data());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
